vlc_bit_packer: RTL and testbench
=================================

# vlc_bit_packer

Receiving end of the sequencer's VLC output windows. Accepts variable-length codewords (right-aligned code plus bit length) from the DC/AC VLC stages while their output enables are high. Packs them MSB-first into 32-bit words for the slice writer, and zero-pads on the flush that closes the AC window. Reports per-slice bit and byte counts for the slice header.

## Interface
- (no parameters)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- slice_start  in  1  single-cycle pulse; clears packer and begins a new slice
- in_valid  in  1  codeword present this cycle
- in_code  in  32  codeword, right-aligned; bits at and above in_len are ignored
- in_len  in  6  codeword length 0..32; 0 appends nothing
- in_flush  in  1  end of slice; applied after any same-cycle codeword
- out_valid  out  1  single-cycle pulse; out_word valid
- out_word  out  32  packed bits; first-received bit is in bit 31
- done  out  1  single-cycle pulse; slice fully emitted
- slice_bits  out  32  total codeword bits accepted this slice
- slice_bytes  out  32  ceil(slice_bits/8), updated with done
- protocol_error  out  1  sticky until slice_start or reset

## Operation
- Internal state:
  - 64-bit accumulator acc, MSB-aligned.
  - Fill count fill, 0..31 between cycles.
  - FSM with states IDLE, PACK, FLUSH, DONE.
- Reset: state IDLE. acc, fill, out_word, slice_bits and slice_bytes are 0. out_valid, done and protocol_error are 0.
- slice_start, in any state, has priority over all other inputs:
  - Clears acc, fill, slice_bits and protocol_error; next state PACK.
  - Any in_valid or in_flush in the same cycle is discarded and sets protocol_error.
- PACK, in_valid with in_len = L ≤ 32:
  - The masked code is placed at acc bits [63-fill : 64-fill-L].
  - fill' = fill + L, which is ≤ 63; slice_bits += L.
  - If fill' ≥ 32: out_word <= acc'[63:32], out_valid <= 1, acc <= acc' << 32, fill <= fill' − 32.
- PACK, in_len > 32: codeword discarded, protocol_error <= 1, no other state change.
- PACK, in_flush (evaluated on fill', after any same-cycle codeword):
  - fill' ≥ 32: emit the word as above and go to FLUSH.
  - 0 < fill' < 32: emit acc'[63:32] zero-padded, assert done, go to DONE.
  - fill' = 0: assert done with no out_valid, go to DONE.
- FLUSH:
  - If fill > 0, emit the zero-padded word.
  - Assert done, clear fill, go to DONE.
- DONE: slice_bits and slice_bytes are held until the next slice_start.
- IDLE, FLUSH and DONE:
  - in_valid and in_flush are ignored.
  - Either one asserted sets protocol_error.
- Arithmetic:
  - slice_bits wraps modulo 2^32.
  - slice_bytes = (slice_bits + 7) >> 3, computed when done is asserted.
- Words emitted per slice = ceil(slice_bits/32).

## Timing
- Latency: a word is emitted on the clock edge that completes its 32nd bit, so out_valid is high in the following cycle.
- Throughput: at most one word per cycle. With L ≤ 32 and fill < 32, no backpressure is ever needed.
- done:
  - Flush with fill' < 32: done is high the cycle after in_flush, coincident with the final out_valid if one exists.
  - Flush with fill' ≥ 32: done is high two cycles after in_flush, with the padded word.
- out_valid and done are never high for more than one consecutive cycle per event.
- Reset mid-slice returns to IDLE immediately. Partial bits are lost and no flush word is emitted.

## Test plan
- Four byte codes: slice_start, then in_code 0xAA, 0xBB, 0xCC, 0xDD with len 8 on consecutive cycles.
  -> One out_word 0xAABBCCDD, one cycle after the 4th code; slice_bits = 32.
- Straddling codes: 0xABCDE len 20, then 0x12345 len 20 with in_flush in the same cycle.
  -> 0xABCDE123, then 0x45000000 with done.
  -> slice_bits = 40, slice_bytes = 5.
- Maximum fill: 0x7FFFFFFF len 31, then 0x00000001 len 32 with in_flush.
  -> 0xFFFFFFFE, then 0x00000002 with done one cycle later (FLUSH path).
  -> slice_bits = 63, slice_bytes = 8.
- Masking: in_code 0xFFFFFFF5 len 4, repeated eight times.
  -> out_word 0x55555555.
- Empty slice: slice_start followed by in_flush alone.
  -> done with out_valid = 0; slice_bits = 0, slice_bytes = 0.
- Error and abort cases:
  - in_len = 33 -> protocol_error = 1, slice_bits unchanged.
  - slice_start mid-slice with fill = 12 -> no word emitted, counts cleared, protocol_error cleared.
  - reset_n low mid-slice -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/vlc_bit_packer.sv
// Packs right-aligned VLC codewords MSB-first into 32-bit words and reports per-slice bit/byte counts.
// Latency: a word appears the cycle after its 32nd bit arrives; a flush with 32+ pending bits adds one cycle before done.
// Backpressure: none; at most one word per cycle, so the input is always accepted.
module vlc_bit_packer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        slice_start,
    input  logic        in_valid,
    input  logic [31:0] in_code,
    input  logic [5:0]  in_len,
    input  logic        in_flush,
    output logic        out_valid,
    output logic [31:0] out_word,
    output logic        done,
    output logic [31:0] slice_bits,
    output logic [31:0] slice_bytes,
    output logic        protocol_error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PACK  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state;
    logic [63:0] acc;
    logic [4:0]  fill;

    logic        len_ok;
    logic [5:0]  add_len;
    logic [63:0] code_mask;
    logic [63:0] masked;
    logic [6:0]  shift;
    logic [63:0] acc_nxt;
    logic [5:0]  fill_nxt;
    logic [31:0] bits_nxt;
    logic        full;

    function automatic logic [31:0] ceil_bytes(input logic [31:0] b);
        return 32'(({1'b0, b} + 33'd7) >> 3);
    endfunction

    // Merge the (possibly zero-length) codeword into the accumulator below the current fill.
    always_comb begin
        len_ok    = (in_len <= 6'd32);
        add_len   = (in_valid && len_ok) ? in_len : 6'd0;
        code_mask = (64'd1 << add_len) - 64'd1;
        masked    = {32'd0, in_code} & code_mask;
        shift     = 7'd64 - {2'b00, fill} - {1'b0, add_len};
        acc_nxt   = acc | (masked << shift);
        fill_nxt  = {1'b0, fill} + add_len;
        bits_nxt  = slice_bits + {26'd0, add_len};
        full      = fill_nxt[5];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            acc            <= '0;
            fill           <= '0;
            out_valid      <= 1'b0;
            out_word       <= '0;
            done           <= 1'b0;
            slice_bits     <= '0;
            slice_bytes    <= '0;
            protocol_error <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            if (slice_start) begin
                acc            <= '0;
                fill           <= '0;
                slice_bits     <= '0;
                slice_bytes    <= '0;
                protocol_error <= in_valid | in_flush;
                state          <= ST_PACK;
            end else begin
                case (state)
                    ST_PACK: begin
                        if (in_valid && !len_ok)
                            protocol_error <= 1'b1;
                        slice_bits <= bits_nxt;
                        fill       <= fill_nxt[4:0];
                        acc        <= full ? {acc_nxt[31:0], 32'd0} : acc_nxt;
                        if (full) begin
                            out_word  <= acc_nxt[63:32];
                            out_valid <= 1'b1;
                        end
                        if (in_flush) begin
                            if (full) begin
                                state <= ST_FLUSH;
                            end else begin
                                if (fill_nxt != 6'd0) begin
                                    out_word  <= acc_nxt[63:32];
                                    out_valid <= 1'b1;
                                end
                                done        <= 1'b1;
                                slice_bytes <= ceil_bytes(bits_nxt);
                                acc         <= '0;
                                fill        <= '0;
                                state       <= ST_DONE;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (in_valid || in_flush)
                            protocol_error <= 1'b1;
                        if (fill != 5'd0) begin
                            out_word  <= acc[63:32];
                            out_valid <= 1'b1;
                        end
                        done        <= 1'b1;
                        slice_bytes <= ceil_bytes(slice_bits);
                        acc         <= '0;
                        fill        <= '0;
                        state       <= ST_DONE;
                    end
                    default: begin
                        if (in_valid || in_flush)
                            protocol_error <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Bench for vlc_bit_packer: bit-queue reference model checked every cycle, directed cases plus random slices.
module tb_vlc_bit_packer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        slice_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_code = '0;
    logic [5:0]  in_len = '0;
    logic        in_flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_word;
    logic        done;
    logic [31:0] slice_bits;
    logic [31:0] slice_bytes;
    logic        protocol_error;

    always #5 clock = ~clock;

    vlc_bit_packer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .slice_start    (slice_start),
        .in_valid       (in_valid),
        .in_code        (in_code),
        .in_len         (in_len),
        .in_flush       (in_flush),
        .out_valid      (out_valid),
        .out_word       (out_word),
        .done           (done),
        .slice_bits     (slice_bits),
        .slice_bytes    (slice_bytes),
        .protocol_error (protocol_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: pending bits in arrival order, words produced, slice bookkeeping.
    bit          bitq[$];
    logic [31:0] model_words[$];
    bit          m_active, m_pend, m_err;
    logic [31:0] m_bits, m_bytes;
    bit          exp_valid, exp_done;
    logic [31:0] exp_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        bitq.delete();
        m_active = 0; m_pend = 0; m_err = 0;
        m_bits = 0; m_bytes = 0;
        exp_valid = 0; exp_done = 0; exp_word = 0;
    endtask

    task automatic model_emit();
        logic [31:0] w;
        bit b;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            b = 1'b0;
            if (bitq.size() > 0) b = bitq.pop_front();
            w = {w[30:0], b};
        end
        exp_valid = 1;
        exp_word  = w;
        model_words.push_back(w);
    endtask

    task automatic model_finish();
        if (bitq.size() > 0) model_emit();
        exp_done = 1;
        m_bytes  = 32'((33'(m_bits) + 33'd7) / 33'd8);
    endtask

    task automatic model_step(input bit ss, input bit v, input logic [31:0] code,
                              input logic [5:0] len, input bit fl);
        exp_valid = 0;
        exp_done  = 0;
        if (ss) begin
            bitq.delete();
            m_bits = 0; m_bytes = 0;
            m_err = v | fl;
            m_active = 1; m_pend = 0;
        end else if (m_active) begin
            if (v) begin
                if (len > 6'd32) m_err = 1;
                else begin
                    for (int i = int'(len) - 1; i >= 0; i--) bitq.push_back(code[i]);
                    m_bits += 32'(len);
                end
            end
            if (bitq.size() >= 32) model_emit();
            if (fl) begin
                m_active = 0;
                if (exp_valid) m_pend = 1;
                else model_finish();
            end
        end else begin
            if (v || fl) m_err = 1;
            if (m_pend) begin
                m_pend = 0;
                model_finish();
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) chk("out_word", out_word, exp_word);
        chk("done", 32'(done), 32'(exp_done));
        chk("slice_bits", slice_bits, m_bits);
        chk("protocol_error", 32'(protocol_error), 32'(m_err));
        if (exp_done) chk("slice_bytes", slice_bytes, m_bytes);
    endtask

    task automatic cyc(input bit ss, input bit v, input logic [31:0] code,
                       input logic [5:0] len, input bit fl);
        slice_start = ss; in_valid = v; in_code = code; in_len = len; in_flush = fl;
        model_step(ss, v, code, len, fl);
        @(posedge clock);
        #1;
        compare();
        slice_start = 0; in_valid = 0; in_code = 0; in_len = 0; in_flush = 0;
    endtask

    task automatic pin_word(input string name, input int idx, input logic [31:0] expv);
        chk(name, (model_words.size() > idx) ? model_words[idx] : 32'hxxxx_xxxx, expv);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_word"}, out_word, 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_slice_bits"}, slice_bits, 32'd0);
        chk({tag, "_slice_bytes"}, slice_bytes, 32'd0);
        chk({tag, "_protocol_error"}, 32'(protocol_error), 32'd0);
    endtask

    initial begin
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Four byte codes.
        model_words.delete();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hAA, 8, 0);
        cyc(0, 1, 32'hBB, 8, 0);
        cyc(0, 1, 32'hCC, 8, 0);
        cyc(0, 1, 32'hDD, 8, 0);
        pin_word("t1_word", 0, 32'hAABBCCDD);
        chk("t1_bits", m_bits, 32'd32);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // Straddling codes, flush with 40 bits pending.
        model_words.delete();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hABCDE, 20, 0);
        cyc(0, 1, 32'h12345, 20, 1);
        cyc(0, 0, 0, 0, 0);
        pin_word("t2_word0", 0, 32'hABCDE123);
        pin_word("t2_word1", 1, 32'h45000000);
        chk("t2_bits", m_bits, 32'd40);
        chk("t2_bytes", m_bytes, 32'd5);

        // Maximum fill, FLUSH path.
        model_words.delete();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h7FFFFFFF, 31, 0);
        cyc(0, 1, 32'h00000001, 32, 1);
        cyc(0, 0, 0, 0, 0);
        pin_word("t3_word0", 0, 32'hFFFFFFFE);
        pin_word("t3_word1", 1, 32'h00000002);
        chk("t3_bits", m_bits, 32'd63);
        chk("t3_bytes", m_bytes, 32'd8);

        // Masking of bits above in_len.
        model_words.delete();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 32'hFFFFFFF5, 4, 0);
        pin_word("t4_word", 0, 32'h55555555);
        cyc(0, 0, 0, 0, 1);

        // Empty slice.
        model_words.delete();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t5_nwords", 32'(model_words.size()), 32'd0);
        chk("t5_bytes", m_bytes, 32'd0);

        // Oversized codeword.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hF, 4, 0);
        cyc(0, 1, 32'hFFFFFFFF, 33, 0);
        chk("t6_err", 32'(m_err), 32'd1);
        chk("t6_bits", m_bits, 32'd4);
        cyc(0, 0, 0, 0, 1);

        // Restart mid-slice with 12 bits pending.
        model_words.delete();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h1, 40, 0);
        cyc(0, 1, 32'hABC, 12, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t7_bits", m_bits, 32'd0);
        chk("t7_err", 32'(m_err), 32'd0);
        chk("t7_nwords", 32'(model_words.size()), 32'd0);
        cyc(0, 0, 0, 0, 1);

        // Reset mid-slice; afterwards a codeword without slice_start must be rejected.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h123, 12, 0);
        reset_n = 1'b0;
        #2;
        check_all_zero("midreset");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        cyc(0, 1, 32'hFFFFFFFF, 32, 0);
        cyc(0, 0, 0, 0, 1);

        // Random slices.
        for (int s = 0; s < 60; s++) begin
            cyc(1, ($urandom_range(0, 9) == 0), $urandom, 6'($urandom_range(0, 32)), 1'b0);
            for (int k = 0; k < int'($urandom_range(0, 20)); k++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 10)      cyc(0, 0, $urandom, 6'($urandom_range(0, 32)), 0);
                else if (r < 14) cyc(0, 1, $urandom, 6'($urandom_range(33, 63)), 0);
                else if (r < 16) cyc(1, 0, 0, 0, 0);
                else             cyc(0, 1, $urandom, 6'($urandom_range(0, 32)), 0);
            end
            cyc(0, 1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 32)), 1);
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                cyc(0, ($urandom_range(0, 7) == 0), $urandom, 6'($urandom_range(0, 32)),
                    ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
